// File: rtl/riscv_pipeline_lsu_if.sv
// Data-memory bus between the load/store unit (master) and a variable-latency memory (slave).
interface riscv_pipeline_lsu_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned NL = XLEN / 8;

    logic            mem_req;
    logic            mem_wr_en;
    logic [XLEN-1:0] mem_addr;
    logic [NL-1:0]   mem_byte_sel;
    logic [XLEN-1:0] mem_wr_data;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rd_data;

    modport master (
        output mem_req, mem_wr_en, mem_addr, mem_byte_sel, mem_wr_data,
        input  mem_ack, mem_rd_data
    );

    modport slave (
        input  mem_req, mem_wr_en, mem_addr, mem_byte_sel, mem_wr_data,
        output mem_ack, mem_rd_data
    );
endinterface

// File: rtl/riscv_pipeline_lsu.sv
// Load/store unit: request/ack data-memory interface with lane steering, extension and timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module riscv_pipeline_lsu #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_lsu_req,
    input  logic                  i_lsu_wr_en,
    input  logic [2:0]            i_lsu_func3,
    input  logic [XLEN-1:0]       i_lsu_addr,
    input  logic [XLEN-1:0]       i_lsu_wr_data,
    output logic                  o_lsu_stall,
    output logic                  o_lsu_done,
    output logic [XLEN-1:0]       o_lsu_rd_data,
    output logic                  o_lsu_err,
    riscv_pipeline_lsu_if.master  mem
);
    localparam int unsigned NL = XLEN / 8;
    localparam int unsigned OB = $clog2(NL);
    localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q;
    logic [CW-1:0]   cnt_q;
    logic            mem_req_q;
    logic            mem_wr_en_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [NL-1:0]   byte_sel_q;
    logic [XLEN-1:0] wr_data_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [OB-1:0]   off_q;
    logic            done_q;
    logic            err_q;
    logic [XLEN-1:0] rd_data_q;

    // Request decode
    logic [1:0]      req_size;
    logic [OB-1:0]   req_off;
    logic [OB-1:0]   size_mask;
    logic [OB-1:0]   aligned_off;
    logic            misaligned;
    logic            trap_misalign;
    logic            illegal_fmt;
    logic            illegal;
    logic [NL-1:0]   lane_mask;
    logic [NL-1:0]   req_sel;
    logic [XLEN-1:0] req_wdata;

    assign req_size = i_lsu_func3[1:0];
    assign req_off  = i_lsu_addr[OB-1:0];

    always_comb begin
        size_mask = '0;
        lane_mask = NL'(1);
        unique case (req_size)
            2'd0: begin size_mask = '0;     lane_mask = NL'(1);  end
            2'd1: begin size_mask = OB'(1); lane_mask = NL'(3);  end
            2'd2: begin size_mask = OB'(3); lane_mask = NL'(15); end
            default: begin size_mask = OB'(7); lane_mask = '1; end
        endcase
    end

    assign misaligned  = |(req_off & size_mask);
    assign aligned_off = req_off & ~size_mask;
    assign req_sel     = lane_mask << aligned_off;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_misalign = misaligned;
`else
    assign trap_misalign = 1'b0;
`endif

    always_comb begin
        illegal_fmt = 1'b0;
        if (i_lsu_wr_en && i_lsu_func3[2]) illegal_fmt = 1'b1;
        if (i_lsu_func3 == 3'b111) illegal_fmt = 1'b1;
        // RV32 has no doubleword accesses and no LWU
        if (XLEN == 32 && (req_size == 2'd3 || i_lsu_func3 == 3'b110)) illegal_fmt = 1'b1;
    end

    assign illegal = illegal_fmt | trap_misalign;

    always_comb begin
        req_wdata = i_lsu_wr_data;
        unique case (req_size)
            2'd0:    req_wdata = {NL{i_lsu_wr_data[7:0]}};
            2'd1:    req_wdata = {(NL/2){i_lsu_wr_data[15:0]}};
            2'd2:    req_wdata = {(NL/4){i_lsu_wr_data[31:0]}};
            default: req_wdata = i_lsu_wr_data;
        endcase
    end

    // Load extraction from the acked lane word
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_data;

    assign shifted = mem.mem_rd_data >> {off_q, 3'b000};

    always_comb begin
        ld_data = shifted;
        unique case (size_q)
            2'd0: ld_data = uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'd1: ld_data = uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'd2: ld_data = uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ld_data = shifted;
        endcase
    end

    logic timeout;
    assign timeout = (MAX_WAIT != 0) && (32'(cnt_q) + 32'd1 == MAX_WAIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            byte_sel_q  <= '0;
            wr_data_q   <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_lsu_req) begin
                        if (illegal) begin
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            rd_data_q <= '0;
                        end else begin
                            state_q     <= StBusy;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_wr_en_q <= i_lsu_wr_en;
                            mem_addr_q  <= {i_lsu_addr[XLEN-1:OB], {OB{1'b0}}};
                            byte_sel_q  <= req_sel;
                            wr_data_q   <= req_wdata;
                            size_q      <= req_size;
                            uns_q       <= i_lsu_func3[2];
                            off_q       <= aligned_off;
                        end
                    end
                end
                StBusy: begin
                    if (mem.mem_ack) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        rd_data_q <= mem_wr_en_q ? '0 : ld_data;
                    end else if (timeout) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        rd_data_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    // The held pipeline request is consumed here
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_lsu_stall      = ((state_q == StIdle) && i_lsu_req) || (state_q == StBusy);
    assign o_lsu_done       = done_q;
    assign o_lsu_err        = err_q;
    assign o_lsu_rd_data    = rd_data_q;
    assign mem.mem_req      = mem_req_q;
    assign mem.mem_wr_en    = mem_wr_en_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_byte_sel = byte_sel_q;
    assign mem.mem_wr_data  = wr_data_q;
endmodule

// File: tb/tb_riscv_pipeline_lsu.sv
// Self-checking bench for riscv_pipeline_lsu (XLEN=32, MAX_WAIT=15) with a byte-level reference model.
module tb_riscv_pipeline_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rd_data;

    int total = 0;
    int bad   = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    always #5 clk = ~clk;

    riscv_pipeline_lsu_if #(.XLEN(32)) mem_if ();

    riscv_pipeline_lsu #(.XLEN(32), .MAX_WAIT(15)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_lsu_req     (req),
        .i_lsu_wr_en   (wr_en),
        .i_lsu_func3   (f3),
        .i_lsu_addr    (addr),
        .i_lsu_wr_data (wdata),
        .o_lsu_stall   (stall),
        .o_lsu_done    (done),
        .o_lsu_rd_data (rd_data),
        .o_lsu_err     (err),
        .mem           (mem_if.master)
    );

    // Reference model: access built byte by byte from the ISA rules
    function automatic void model(input logic w, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] md, output bit ill,
                                  output logic [3:0] sel, output logic [31:0] ea,
                                  output logic [31:0] ewd, output logic [31:0] erd);
        int size;
        int off;
        logic [31:0] v;
        size = 1 << f[1:0];
        off  = int'(a % 4);
        ill  = (f[1:0] == 2'b11) || (f == 3'b110) || (w && f[2]);
        if (TrapEn && (off % size) != 0) ill = 1'b1;
        sel = '0; ea = a & ~32'h3; ewd = '0; erd = '0;
        if (ill) return;
        off = off - (off % size);
        sel = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % size) +: 8];
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = md[8*(off+i) +: 8];
        if (!f[2] && v[8*size-1]) for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        erd = w ? 32'h0 : v;
    endfunction

    // Drives one access and plays memory with ack after 'wt' wait cycles (wt<0: never)
    task automatic run_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] md, input int wt,
                              output int stall_n, output int done_cyc, output int req_n,
                              output logic [31:0] o_rd, output logic o_err,
                              output logic [31:0] o_addr, output logic [3:0] o_sel,
                              output logic [31:0] o_wd, output logic o_wr);
        @(posedge clk); #1;
        req = 1'b1; wr_en = w; f3 = f; addr = a; wdata = wd;
        mem_if.mem_ack = 1'b0;
        stall_n = 0; done_cyc = -1; req_n = 0;
        o_rd = 'x; o_err = 1'bx; o_addr = '0; o_sel = '0; o_wd = '0; o_wr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            mem_if.mem_ack     = 1'b0;
            mem_if.mem_rd_data = $urandom;
            if (mem_if.mem_req) begin
                req_n++;
                o_addr = mem_if.mem_addr; o_sel = mem_if.mem_byte_sel;
                o_wd = mem_if.mem_wr_data; o_wr = mem_if.mem_wr_en;
                if (req_n - 1 == wt) begin
                    mem_if.mem_ack     = 1'b1;
                    mem_if.mem_rd_data = md;
                end
            end
            if (done) begin
                done_cyc = c; o_rd = rd_data; o_err = err;
                req = 1'b0;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
    endtask

    int sn, dc, rn;
    logic [31:0] ord, oaddr, owd;
    logic [3:0]  osel;
    logic        oerr, owr;

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", rd_data); end
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mreq got=%b exp=0", mem_if.mem_req); end
        total++; if ({mem_if.mem_addr, mem_if.mem_wr_data, mem_if.mem_byte_sel, mem_if.mem_wr_en} !== '0) begin
            bad++; $display("FAIL rst_bus got=%h/%h/%h/%b exp=0", mem_if.mem_addr, mem_if.mem_wr_data,
                            mem_if.mem_byte_sel, mem_if.mem_wr_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_lw_zero_wait();
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, sn, dc, rn, ord, oerr, oaddr, osel, owd, owr);
        total++; if (oaddr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=100", oaddr); end
        total++; if (osel !== 4'hF) begin bad++; $display("FAIL lw_sel got=%h exp=f", osel); end
        total++; if (dc !== 2) begin bad++; $display("FAIL lw_done_cyc got=%0d exp=2", dc); end
        total++; if (ord !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rd got=%h exp=deadbeef", ord); end
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", oerr); end
        total++; if (sn !== 2) begin bad++; $display("FAIL lw_stall got=%0d exp=2", sn); end
    endtask

    task automatic test_sb_wait();
        run_access(1'b1, 3'b000, 32'h103, 32'hA5, 32'h12345678, 3, sn, dc, rn, ord, oerr, oaddr, osel, owd, owr);
        total++; if (osel !== 4'h8) begin bad++; $display("FAIL sb_sel got=%h exp=8", osel); end
        total++; if (owd !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wd got=%h exp=a5a5a5a5", owd); end
        total++; if (owr !== 1'b1) begin bad++; $display("FAIL sb_wr got=%b exp=1", owr); end
        total++; if (sn !== 5) begin bad++; $display("FAIL sb_stall got=%0d exp=5", sn); end
        total++; if (dc !== 5) begin bad++; $display("FAIL sb_done_cyc got=%0d exp=5", dc); end
        total++; if (ord !== 32'h0) begin bad++; $display("FAIL sb_rd got=%h exp=0", ord); end
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL sb_err got=%b exp=0", oerr); end
    endtask

    task automatic test_lb_lbu();
        run_access(1'b0, 3'b000, 32'h202, 32'h0, 32'h00800000, 1, sn, dc, rn, ord, oerr, oaddr, osel, owd, owr);
        total++; if (ord !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rd got=%h exp=ffffff80", ord); end
        run_access(1'b0, 3'b100, 32'h202, 32'h0, 32'h00800000, 0, sn, dc, rn, ord, oerr, oaddr, osel, owd, owr);
        total++; if (ord !== 32'h00000080) begin bad++; $display("FAIL lbu_rd got=%h exp=00000080", ord); end
        total++; if (osel !== 4'h4) begin bad++; $display("FAIL lbu_sel got=%h exp=4", osel); end
    endtask

    task automatic test_misaligned();
        bit ill;
        logic [3:0] es;
        logic [31:0] ea, ew, er;
        model(1'b0, 3'b001, 32'h101, 32'h0, 32'hCAFEF00D, ill, es, ea, ew, er);
        run_access(1'b0, 3'b001, 32'h101, 32'h0, 32'hCAFEF00D, 0, sn, dc, rn, ord, oerr, oaddr, osel, owd, owr);
        total++; if (dc !== (ill ? 1 : 2)) begin bad++; $display("FAIL lh_mis_done_cyc got=%0d exp=%0d", dc, ill ? 1 : 2); end
        total++; if (rn !== (ill ? 0 : 1)) begin bad++; $display("FAIL lh_mis_reqs got=%0d exp=%0d", rn, ill ? 0 : 1); end
        total++; if (oerr !== ill) begin bad++; $display("FAIL lh_mis_err got=%b exp=%b", oerr, ill); end
        total++; if (ord !== er) begin bad++; $display("FAIL lh_mis_rd got=%h exp=%h", ord, er); end
        total++; if (osel !== es) begin bad++; $display("FAIL lh_mis_sel got=%h exp=%h", osel, es); end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h11111111, -1, sn, dc, rn, ord, oerr, oaddr, osel, owd, owr);
        total++; if (rn !== 15) begin bad++; $display("FAIL to_reqs got=%0d exp=15", rn); end
        total++; if (dc !== 16) begin bad++; $display("FAIL to_done_cyc got=%0d exp=16", dc); end
        total++; if (oerr !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", oerr); end
        total++; if (ord !== 32'h0) begin bad++; $display("FAIL to_rd got=%h exp=0", ord); end
        // Late ack while idle must not produce any completion
        @(negedge clk);
        mem_if.mem_ack = 1'b1; mem_if.mem_rd_data = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        total++; if ({done, stall, mem_if.mem_req} !== 3'b000) begin
            bad++; $display("FAIL late_ack got=%b exp=000", {done, stall, mem_if.mem_req});
        end
        mem_if.mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        req = 1'b1; wr_en = 1'b0; f3 = 3'b010; addr = 32'h40; wdata = '0;
        mem_if.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL rb_busy_req got=%b exp=1", mem_if.mem_req); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL rb_req got=%b exp=0", mem_if.mem_req); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rb_stall_hi got=%b exp=1", stall); end
        total++; if ({done, err, rd_data, mem_if.mem_addr, mem_if.mem_byte_sel} !== '0) begin
            bad++; $display("FAIL rb_outs got=%b/%b/%h/%h/%h exp=0", done, err, rd_data, mem_if.mem_addr,
                            mem_if.mem_byte_sel);
        end
        req = 1'b0; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rb_stall_lo got=%b exp=0", stall); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        bit ill;
        logic w;
        logic [2:0] f;
        logic [31:0] a, wd, md, es32, ea, ew, er;
        logic [3:0] es;
        int wt, edc;
        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom_range(0, 1));
            f  = w ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 6));
            a  = $urandom; wd = $urandom; md = $urandom;
            wt = $urandom_range(0, 4);
            model(w, f, a, wd, md, ill, es, ea, ew, er);
            edc = ill ? 1 : 2 + wt;
            es32 = {28'h0, es};
            run_access(w, f, a, wd, md, wt, sn, dc, rn, ord, oerr, oaddr, osel, owd, owr);
            total++; if (dc !== edc) begin bad++; $display("FAIL rnd%0d_done_cyc got=%0d exp=%0d", n, dc, edc); end
            total++; if (sn !== edc) begin bad++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", n, sn, edc); end
            total++; if (oerr !== ill) begin bad++; $display("FAIL rnd%0d_err got=%b exp=%b", n, oerr, ill); end
            total++; if (ord !== er) begin bad++; $display("FAIL rnd%0d_rd got=%h exp=%h", n, ord, er); end
            total++; if ({28'h0, osel} !== es32) begin bad++; $display("FAIL rnd%0d_sel got=%h exp=%h", n, osel, es); end
            if (!ill) begin
                total++; if (oaddr !== ea) begin bad++; $display("FAIL rnd%0d_addr got=%h exp=%h", n, oaddr, ea); end
                total++; if (owd !== ew && w) begin bad++; $display("FAIL rnd%0d_wd got=%h exp=%h", n, owd, ew); end
                total++; if (owr !== w) begin bad++; $display("FAIL rnd%0d_wr got=%b exp=%b", n, owr, w); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr_en = 1'b0; f3 = '0; addr = '0; wdata = '0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rd_data = '0;
        test_reset();
        test_lw_zero_wait();
        test_sb_wait();
        test_lb_lbu();
        test_misaligned();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_pipeline_lsu.md
# riscv_pipeline_lsu

Parametrised load/store unit between the EX/MEM stage of the pipelined RV32I/RV64I core and a data memory with variable latency. Generalises the combinational data-memory interface into a request/acknowledge block: it aligns and replicates store data, generates byte lane selects, extracts and sign/zero-extends load data, stalls the pipeline while memory is busy, and reports misaligned, illegal and timed-out accesses.

## Interface
- `XLEN`, 32: data/address width, 32 or 64; lanes `NL = XLEN/8`, offset bits `OB = log2(NL)`.
- `MAX_WAIT`, 15: BUSY cycles without ack before timeout; 0 disables timeout.

- `i_clk` in 1: clock, all state on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_lsu_req` in 1: access valid; held with its fields stable by pipeline while `o_lsu_stall`=1.
- `i_lsu_wr_en` in 1: 1 = store, 0 = load.
- `i_lsu_func3` in 3: RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
- `i_lsu_addr` in XLEN: byte address.
- `i_lsu_wr_data` in XLEN: store source, LSB-justified.
- `o_lsu_stall` out 1: pipeline must hold.
- `o_lsu_done` out 1: one-cycle completion pulse.
- `o_lsu_rd_data` out XLEN: extended load result, valid with `o_lsu_done`.
- `o_lsu_err` out 1: access fault, valid with `o_lsu_done`.
- `o_lsu_mem_req` out 1: memory request, held until ack.
- `o_lsu_mem_wr_en` out 1: memory write.
- `o_lsu_mem_addr` out XLEN: lane-aligned address (low OB bits zero).
- `o_lsu_mem_byte_sel` out NL: active lanes.
- `o_lsu_mem_wr_data` out XLEN: lane-replicated store data.
- `i_lsu_mem_ack` in 1: memory completion; may assert in the first req cycle.
- `i_lsu_mem_rd_data` in XLEN: full lane word, valid with ack.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `i_lsu_req`=0: no action.
- IDLE, `i_lsu_req`=1, legal: register mem_addr, byte_sel, wr_data, wr_en, func3, offset; go BUSY.
- IDLE, illegal (funct3 011/110 when XLEN=32, funct3 1xx on store, or misaligned with trap enabled): no memory request; go DONE with err=1, rd_data=0.
- BUSY: `o_lsu_mem_req`=1; on ack capture extended load data (stores: rd_data=0), err=0, go DONE; timeout counter increments each BUSY cycle without ack; at `MAX_WAIT` drop req, go DONE with err=1, rd_data=0.
- DONE: done=1, stall=0; unconditionally back to IDLE (the held request is consumed).
- Byte sel: size 1/2/4/8 bytes => 1/3/15/255 shifted left by offset.
- Store data: byte replicated NL times, half NL/2 times, word NL/4 times, double as-is.
- Load extract: lane at offset; LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend to XLEN.
- Ack outside BUSY is ignored.
- `o_lsu_stall` = (IDLE & `i_lsu_req`) | BUSY; combinational.

## Timing
- Reset: state IDLE, counter 0, all registered outputs 0 (mem_req, mem_wr_en, mem_addr, byte_sel, wr_data, done, err, rd_data); reset mid-BUSY drops mem_req next cycle, transaction is abandoned.
- Zero-wait access: cycle 0 req seen (stall=1), cycle 1 BUSY + ack (stall=1), cycle 2 DONE (stall=0, done=1); 2 stall cycles, +1 per wait state.
- Illegal access: cycle 0 stall=1, cycle 1 DONE with err.
- Timeout: mem_req high exactly `MAX_WAIT` cycles, then DONE.
- New request accepted no earlier than the cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: half/word/double with offset not a multiple of size is a fault (no memory access, err=1).
- Undefined: offset bits below access size are forced to zero; access proceeds aligned-down, no err.

## Test plan
- XLEN=32, LW addr 0x100, ack in first BUSY cycle, mem data 0xDEADBEEF -> mem_addr 0x100, byte_sel 0xF, done at cycle 2, rd_data 0xDEADBEEF, err 0.
- SB addr 0x103, data 0x000000A5, ack after 3 wait cycles -> byte_sel 0x8, wr_data 0xA5A5A5A5, stall 5 cycles, done rd_data 0.
- LB vs LBU addr 0x202, mem data 0x00800000 -> 0xFFFFFF80 and 0x00000080.
- LH addr 0x101 -> with macro: no mem_req, done+err at cycle 1; without: access to 0x100, byte_sel 0x3.
- MAX_WAIT=15, LW with ack never asserted -> mem_req high 15 cycles, then done+err, rd_data 0; late ack ignored.
- i_rst asserted during BUSY -> next cycle mem_req=0, stall follows i_lsu_req, all outputs 0.
